pattern_detector_param: RTL and testbench

Parametrised serial bit-pattern detector, successor to the fixed-sequence detector. It compares an MSB-first serial stream against a run-time loadable pattern with a per-bit don't-care mask. Overlapping or non-overlapping detection is selectable, and it keeps a saturating match counter. It sits directly on a serial data line (one bit per clock when x_valid is high) and feeds status/interrupt logic.

---
 rtl/pattern_detector_param_if.sv | 27 ++
 rtl/pattern_detector_param.sv | 96 +++++++++
 tb/tb_pattern_detector_param.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_detector_param_if.sv
// Serial-line bundle for the parametrised pattern detector.
// The master drives the data and pattern-load side; the slave is the detector.
interface pattern_detector_param_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic             x;
  logic             x_valid;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic [PAT_W-1:0] mask_in;
  logic             overlap;
  logic             y;
  logic [CNT_W-1:0] match_count;
  logic             count_sat;
  logic             armed;

  modport master (
    output x, x_valid, pat_load, pat_in, mask_in, overlap,
    input  y, match_count, count_sat, armed
  );

  modport slave (
    input  x, x_valid, pat_load, pat_in, mask_in, overlap,
    output y, match_count, count_sat, armed
  );
endinterface

// File: rtl/pattern_detector_param.sv
// MSB-first serial pattern detector with run-time loadable pattern/mask,
// selectable overlapping detection and a saturating match counter.
module pattern_detector_param #(
  parameter int               PAT_W       = 4,
  parameter int               CNT_W       = 8,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(4'b1011)
) (
  input logic clk,
  input logic rst,
  pattern_detector_param_if.slave io_bus
);

  localparam int             FW   = $clog2(PAT_W + 1);
  localparam logic [FW-1:0]  FULL = FW'(PAT_W);

  typedef enum logic [1:0] {S_EMPTY, S_FILLING, S_ARMED} state_t;

  state_t           r_state;
  logic [FW-1:0]    r_fill;
  logic [PAT_W-1:0] r_sh;
  logic [PAT_W-1:0] r_pat;
  logic [PAT_W-1:0] r_mask;
  logic             r_y;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;
  logic             r_armed;

  logic [PAT_W-1:0] w_sh_next;
  logic [FW-1:0]    w_fill_inc;
  logic             w_match;
  logic [CNT_W-1:0] w_cnt_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  // Newest bit enters at the LSB, so the pattern reads in arrival order.
  assign w_sh_next  = {r_sh[PAT_W-2:0], io_bus.x};
  assign w_fill_inc = (r_state == S_ARMED) ? FULL : r_fill + FW'(1);
  assign w_match    = io_bus.x_valid && (w_fill_inc == FULL) &&
                      (((w_sh_next ^ r_pat) & r_mask) == '0);
  assign w_cnt_next = sat_inc(r_cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_fill  <= '0;
      r_sh    <= '0;
      r_pat   <= DEFAULT_PAT;
      r_mask  <= '1;
      r_y     <= 1'b0;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
      r_armed <= 1'b0;
    end else if (io_bus.pat_load) begin
      // A load discards any bit presented in the same cycle.
      r_pat   <= io_bus.pat_in;
      r_mask  <= io_bus.mask_in;
      r_state <= S_EMPTY;
      r_fill  <= '0;
      r_sh    <= '0;
      r_y     <= 1'b0;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_y <= w_match;
      if (io_bus.x_valid) begin
        r_sh <= w_sh_next;
        if (w_match && !io_bus.overlap) begin
          r_state <= S_EMPTY;
          r_fill  <= '0;
          r_armed <= 1'b0;
        end else if (w_fill_inc == FULL) begin
          r_state <= S_ARMED;
          r_fill  <= FULL;
          r_armed <= 1'b1;
        end else begin
          r_state <= S_FILLING;
          r_fill  <= w_fill_inc;
          r_armed <= 1'b0;
        end
      end
      if (w_match) begin
        r_cnt <= w_cnt_next;
        r_sat <= r_sat | (w_cnt_next == '1);
      end
    end
  end

  assign io_bus.y           = r_y;
  assign io_bus.match_count = r_cnt;
  assign io_bus.count_sat   = r_sat;
  assign io_bus.armed       = r_armed;

endmodule

// File: tb/tb_pattern_detector_param.sv
// Scoreboard bench for pattern_detector_param: directed streams with
// hand-marked match positions; a monitor pops expected pulses on every y.
module tb_pattern_detector_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pattern_detector_param_if #(.PAT_W(4), .CNT_W(8)) bus ();
  pattern_detector_param_if #(.PAT_W(4), .CNT_W(2)) bus2 ();

  pattern_detector_param #(.PAT_W(4), .CNT_W(8), .DEFAULT_PAT(4'b1011)) dut (
    .clk(clk), .rst(rst), .io_bus(bus)
  );
  pattern_detector_param #(.PAT_W(4), .CNT_W(2), .DEFAULT_PAT(4'b1011)) dut_sat (
    .clk(clk), .rst(rst), .io_bus(bus2)
  );

  typedef struct {
    int cyc;
    int cnt;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc        = 0;
  int   exp_cnt    = 0;
  int   compared   = 0;
  int   mismatched = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every y pulse must match the oldest expected pulse.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.y !== 1'b0) begin
      compared++;
      if (q.size() == 0) begin
        mismatched++;
        $display("FAIL y_unexpected: y=%b at cycle %0d count=%0d, required no pulse",
                 bus.y, cyc, bus.match_count);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || bus.match_count !== e.cnt[7:0]) begin
          mismatched++;
          $display("FAIL y_pulse: got pulse at cycle %0d count=%0d, required cycle %0d count=%0d",
                   cyc, bus.match_count, e.cyc, e.cnt);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic xv, input logic xb, input logic pl,
                       input logic [3:0] pi, input logic [3:0] mi);
    bus.x_valid = xv;  bus2.x_valid = xv;
    bus.x = xb;        bus2.x = xb;
    bus.pat_load = pl; bus2.pat_load = pl;
    bus.pat_in = pi;   bus2.pat_in = pi;
    bus.mask_in = mi;  bus2.mask_in = mi;
  endtask

  task automatic set_ov(input logic ov);
    bus.overlap = ov;
    bus2.overlap = ov;
  endtask

  task automatic send_bit(input logic b, input logic hit);
    drive(1'b1, b, 1'b0, 4'h0, 4'h0);
    @(posedge clk); #1;
    if (hit) begin
      exp_cnt++;
      q.push_back('{cyc, exp_cnt});
    end
  endtask

  task automatic idle_cycle();
    drive(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
    @(posedge clk); #1;
  endtask

  // bits/hits are MSB-first: element 0 of the stream is bit n-1 of the vector.
  task automatic send_vec(input logic [31:0] bits, input int n, input logic [31:0] hits,
                          input int gap, input int arm_from);
    for (int i = 0; i < n; i++) begin
      send_bit(bits[n-1-i], hits[n-1-i]);
      if (arm_from >= 0) chk($sformatf("armed_bit%0d", i), {31'd0, bus.armed}, {31'd0, i >= arm_from});
      if (i < n - 1)
        for (int g = 0; g < gap; g++) idle_cycle();
    end
    drive(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
  endtask

  task automatic load(input logic [3:0] p, input logic [3:0] m, input logic xv);
    drive(xv, 1'b1, 1'b1, p, m);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    exp_cnt = 0;
  endtask

  task automatic end_test(input string name);
    @(negedge clk); #1;
    chk({name, "_pending"}, q.size(), 0);
    q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_async_count", {24'd0, bus.match_count}, 0);
    chk("rst_async_armed", {31'd0, bus.armed}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    exp_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    set_ov(1'b1);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_y", {31'd0, bus.y}, 0);
    chk("reset_count", {24'd0, bus.match_count}, 0);
    chk("reset_sat", {31'd0, bus.count_sat}, 0);
    chk("reset_armed", {31'd0, bus.armed}, 0);
    rst = 1'b0;

    // Default pattern 1011, overlapping, continuous stream.
    send_vec(32'b01101001110100011011110000101110, 32,
             32'b0000000000000000000_1_000000000_1_00, 0, 3);
    end_test("default_stream");
    chk("default_count", {24'd0, bus.match_count}, 2);

    // Pattern x101: overlap on vs off.
    set_ov(1'b1);
    load(4'b0101, 4'b0111, 1'b0);
    send_vec(32'b1010101, 7, 32'b0000101, 0, -1);
    end_test("mask_ov1");
    chk("mask_ov1_count", {24'd0, bus.match_count}, 2);
    set_ov(1'b0);
    load(4'b0101, 4'b0111, 1'b0);
    send_vec(32'b1010101, 7, 32'b0000100, 0, -1);
    end_test("mask_ov0");
    chk("mask_ov0_count", {24'd0, bus.match_count}, 1);

    // Don't-care middle bits 1xx1, non-overlapping.
    load(4'b1001, 4'b1001, 1'b0);
    send_vec(32'b11111011, 8, 32'b00010001, 0, -1);
    end_test("dc_hits");
    chk("dc_count", {24'd0, bus.match_count}, 2);
    send_vec(32'b0111, 4, 32'b0000, 0, -1);
    end_test("dc_nohit");
    chk("dc_nohit_count", {24'd0, bus.match_count}, 2);

    // x_valid gaps of three cycles between bits.
    set_ov(1'b1);
    load(4'b1011, 4'b1111, 1'b0);
    send_vec(32'b1011, 4, 32'b0001, 3, -1);
    end_test("gaps");
    chk("gaps_count", {24'd0, bus.match_count}, 1);

    // Saturation on the 2-bit counter instance.
    set_ov(1'b0);
    load(4'b1011, 4'b1111, 1'b0);
    send_vec(32'hBB, 8, 32'b00010001, 0, -1);
    @(negedge clk);
    chk("sat2_count_after2", {30'd0, bus2.match_count}, 2);
    chk("sat2_flag_after2", {31'd0, bus2.count_sat}, 0);
    send_vec(32'hB, 4, 32'b0001, 0, -1);
    @(negedge clk);
    chk("sat2_count_after3", {30'd0, bus2.match_count}, 3);
    chk("sat2_flag_after3", {31'd0, bus2.count_sat}, 1);
    send_vec(32'hBBBBB, 20, 32'b00010001000100010001, 0, -1);
    end_test("sat");
    chk("sat2_count_hold", {30'd0, bus2.match_count}, 3);
    chk("sat2_flag_hold", {31'd0, bus2.count_sat}, 1);
    chk("sat8_count", {24'd0, bus.match_count}, 8);
    load(4'b1011, 4'b1111, 1'b0);
    chk("sat2_count_cleared", {30'd0, bus2.match_count}, 0);
    chk("sat2_flag_cleared", {31'd0, bus2.count_sat}, 0);

    // All-zero mask: every armed bit matches.
    set_ov(1'b1);
    load(4'b0000, 4'b0000, 1'b0);
    send_vec(32'b000000, 6, 32'b000111, 0, -1);
    end_test("mask0_ov1");
    set_ov(1'b0);
    load(4'b0000, 4'b0000, 1'b0);
    send_vec(32'hA5, 8, 32'b00010001, 0, -1);
    end_test("mask0_ov0");
    chk("mask0_ov0_count", {24'd0, bus.match_count}, 2);

    // Reset mid-pattern restores the default pattern and restarts fill.
    do_reset();
    send_vec(32'b101, 3, 32'b000, 0, -1);
    do_reset();
    send_vec(32'b1, 1, 32'b0, 0, 99);
    send_vec(32'b011, 3, 32'b001, 0, -1);
    end_test("rst_mid");
    chk("rst_mid_count", {24'd0, bus.match_count}, 1);

    // Load with a simultaneous valid bit discards that bit.
    send_vec(32'b101, 3, 32'b000, 0, -1);
    load(4'b1011, 4'b1111, 1'b1);
    send_vec(32'b101, 3, 32'b000, 0, 99);
    send_vec(32'b1, 1, 32'b1, 0, -1);
    end_test("load_mid");
    chk("load_mid_count", {24'd0, bus.match_count}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
